// File: rtl/bsg_trace_dut_pkg.sv
// Shared types for the trace-replay transform DUT.
// Holds the per-beat transform encoding used by the top level.
package bsg_trace_dut_pkg;

  typedef enum logic [1:0] {
    e_xform_pass,
    e_xform_inv,
    e_xform_inc,
    e_xform_rol
  } bsg_trace_xform_e;

  localparam int unsigned xform_sel_w_lp = 2;

endpackage

// File: rtl/bsg_trace_dut_fifo.sv
// Count-tracked FIFO with async-reset pointers and occupancy.
// Ready/valid come straight from registered count: no input-to-output path.
module bsg_trace_dut_fifo
  import bsg_trace_dut_pkg::*;
#(
  parameter int unsigned width_p = 80,
  parameter int unsigned els_p   = 4,
  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                v_i,
  input  logic [width_p-1:0]  data_i,
  output logic                ready_o,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  input  logic                ready_i,
  output logic [cnt_w_lp-1:0] count_o
);

  localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                enq, deq;

  assign ready_o = (count_q != full_lp);
  assign v_o     = (count_q != '0);
  assign enq     = v_i & ready_o;
  assign deq     = v_o & ready_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
    if (deq) rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
    unique case ({enq, deq})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; count gates its visibility.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_trace_replay_xform_dut.sv
// Buffered trace-replay DUT: per-beat transform applied at enqueue,
// results held in a FIFO and returned on a valid/ready channel.
module bsg_trace_replay_xform_dut
  import bsg_trace_dut_pkg::*;
#(
  parameter int unsigned payload_width_p = 80,
  parameter int unsigned els_p           = 4,
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [1:0]                 mode_i,
  input  logic                       v_i,
  input  logic [payload_width_p-1:0] data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [payload_width_p-1:0] data_o,
  input  logic                       ready_i,
  output logic [cnt_w_lp-1:0]        count_o
);

  localparam int unsigned w_lp = payload_width_p;

  bsg_trace_xform_e       mode;
  logic [w_lp-1:0]        xform;

  assign mode = bsg_trace_xform_e'(mode_i);

  always_comb begin
    xform = data_i;
    unique case (mode)
      e_xform_pass: xform = data_i;
      e_xform_inv:  xform = ~data_i;
      e_xform_inc:  xform = data_i + w_lp'(1);
      e_xform_rol:  xform = {data_i[w_lp-2:0], data_i[w_lp-1]};
      default:      xform = data_i;
    endcase
  end

  bsg_trace_dut_fifo #(
    .width_p (payload_width_p),
    .els_p   (els_p)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (v_i),
    .data_i  (xform),
    .ready_o (ready_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .ready_i (ready_i),
    .count_o (count_o)
  );

endmodule

// File: tb/tb_bsg_trace_replay_xform_dut.sv
// Directed bench for the transform FIFO DUT (8-bit payload, depth 4).
// Expected values are hand-computed constants.
module tb_bsg_trace_replay_xform_dut;

  logic       clk_i;
  logic       reset_i;
  logic [1:0] mode_i;
  logic       v_i;
  logic [7:0] data_i;
  logic       ready_o;
  logic       v_o;
  logic [7:0] data_o;
  logic       ready_i;
  logic [2:0] count_o;

  int checks;
  int errors;

  bsg_trace_replay_xform_dut #(
    .payload_width_p (8),
    .els_p           (4)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .mode_i  (mode_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .ready_i (ready_i),
    .count_o (count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic single(input logic [7:0] d,
                        input logic [1:0] m,
                        input logic [7:0] exp);
    v_i = 1'b1; data_i = d; mode_i = m; ready_i = 1'b0;
    step();
    v_i = 1'b0; data_i = 8'hxx; mode_i = 2'b11;
    chk("single_v", 32'(v_o), 32'd1);
    chk("single_data", 32'(data_o), 32'(exp));
    chk("single_cnt", 32'(count_o), 32'd1);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk("single_empty", 32'(count_o), 32'd0);
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] m);
    v_i = 1'b1; data_i = d; mode_i = m;
    step();
    v_i = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    chk(tag, 32'(data_o), 32'(exp));
    chk({tag, "_v"}, 32'(v_o), 32'd1);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_i = 1'b1; v_i = 1'b0; ready_i = 1'b0;
    mode_i = 2'd0; data_i = 8'h00;
    step(); step();
    chk("rst_cnt", 32'(count_o), 32'd0);
    chk("rst_v", 32'(v_o), 32'd0);
    chk("rst_rdy", 32'(ready_o), 32'd1);
    reset_i = 1'b0;
    step();
    chk("post_rst_v", 32'(v_o), 32'd0);

    single(8'h5A, 2'd0, 8'h5A);
    single(8'h5A, 2'd1, 8'hA5);
    single(8'hFF, 2'd2, 8'h00);
    single(8'h81, 2'd3, 8'h03);

    // Fill with consumer stalled
    for (int i = 1; i <= 4; i++) begin
      push(8'(i), 2'd0);
      chk("fill_cnt", 32'(count_o), 32'(i));
    end
    chk("full_rdy", 32'(ready_o), 32'd0);
    push(8'h05, 2'd0);
    chk("full_reject_cnt", 32'(count_o), 32'd4);
    for (int i = 1; i <= 4; i++) pop("drain", 8'(i));
    chk("drain_cnt", 32'(count_o), 32'd0);
    chk("drain_v", 32'(v_o), 32'd0);

    // Full with simultaneous offer and consume: no full bypass
    for (int i = 1; i <= 4; i++) push(8'(8'h10 + i), 2'd0);
    v_i = 1'b1; data_i = 8'h55; mode_i = 2'd0; ready_i = 1'b1;
    chk("fb_head", 32'(data_o), 32'h11);
    step();
    chk("fb_cnt_deq_only", 32'(count_o), 32'd3);
    chk("fb_head2", 32'(data_o), 32'h12);
    ready_i = 1'b0;
    step();
    v_i = 1'b0;
    chk("fb_cnt_enq", 32'(count_o), 32'd4);
    pop("fb_d0", 8'h12);
    pop("fb_d1", 8'h13);
    pop("fb_d2", 8'h14);
    pop("fb_d3", 8'h55);
    chk("fb_empty", 32'(count_o), 32'd0);

    // Streaming increment, one beat per cycle
    ready_i = 1'b1; mode_i = 2'd2;
    for (int i = 0; i < 16; i++) begin
      v_i = 1'b1; data_i = 8'(i);
      step();
      chk("stream_cnt", 32'(count_o), 32'd1);
      chk("stream_data", 32'(data_o), 32'(i + 1));
    end
    v_i = 1'b0;
    step();
    ready_i = 1'b0;
    chk("stream_end_cnt", 32'(count_o), 32'd0);

    // Per-beat mode selection
    push(8'h10, 2'd0);
    push(8'h10, 2'd1);
    push(8'h10, 2'd2);
    push(8'h10, 2'd3);
    mode_i = 2'd1;
    pop("mode_pass", 8'h10);
    pop("mode_inv", 8'hEF);
    pop("mode_inc", 8'h11);
    pop("mode_rol", 8'h20);

    // Asynchronous reset mid-cycle with three beats buffered
    push(8'hA1, 2'd0);
    push(8'hA2, 2'd0);
    push(8'hA3, 2'd0);
    chk("pre_rst_cnt", 32'(count_o), 32'd3);
    #2;
    reset_i = 1'b1;
    #1;
    chk("arst_v", 32'(v_o), 32'd0);
    chk("arst_cnt", 32'(count_o), 32'd0);
    chk("arst_rdy", 32'(ready_o), 32'd1);
    step();
    reset_i = 1'b0;
    step();
    chk("arst_rel_v", 32'(v_o), 32'd0);
    chk("arst_rel_cnt", 32'(count_o), 32'd0);
    push(8'h3C, 2'd0);
    pop("arst_fresh", 8'h3C);
    chk("arst_final_cnt", 32'(count_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
